// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response wrapper around an external combinational ALU,
// with an internal iterative restoring divider for the DIV_OP opcode.
// Optional macro ALU_SEQ_DIVZERO_EN: divide-by-zero short-circuit and rsp_divzero flag.
module alu_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [4:0]  DIV_OP = 5'b00011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_branch,
  output logic             rsp_divzero,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_branch
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;
`ifdef ALU_SEQ_DIVZERO_EN
  logic             divzero_q, divzero_d;
`endif

  logic [4:0]       bit_idx;
  logic             a_bit;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   divisor_ext;
  logic             quo_bit;

  // Dividend bit for this iteration is selected with a mask so the 5-bit
  // counter can address any WIDTH without a width-mismatched bit select.
  always_comb begin
    bit_idx     = 5'(WIDTH - 1) - cnt_q;
    a_bit       = |(a_q & (WIDTH'(1) << bit_idx));
    rem_shift   = (rem_q << 1) | (WIDTH + 1)'(a_bit);
    divisor_ext = {1'b0, b_q};
    quo_bit     = (rem_shift >= divisor_ext);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    branch_d = branch_q;
`ifdef ALU_SEQ_DIVZERO_EN
    divzero_d = divzero_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          cnt_d = '0;
          rem_d = '0;
          quo_d = '0;
          if (req_op == DIV_OP) state_d = DIV;
          else                  state_d = EXEC;
`ifdef ALU_SEQ_DIVZERO_EN
          if ((req_op == DIV_OP) && (req_b == '0)) begin
            state_d   = DONE;
            result_d  = '1;
            branch_d  = 1'b0;
            divzero_d = 1'b1;
          end
`endif
        end
      end

      EXEC: begin
        result_d = alu_result;
        branch_d = alu_branch;
`ifdef ALU_SEQ_DIVZERO_EN
        divzero_d = 1'b0;
`endif
        state_d  = DONE;
      end

      DIV: begin
        rem_d = quo_bit ? (rem_shift - divisor_ext) : rem_shift;
        quo_d = (quo_q << 1) | WIDTH'(quo_bit);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1)) begin
          cnt_d    = '0;
          result_d = (quo_q << 1) | WIDTH'(quo_bit);
          branch_d = 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
          divzero_d = 1'b0;
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      branch_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
      divzero_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      branch_q <= branch_d;
`ifdef ALU_SEQ_DIVZERO_EN
      divzero_q <= divzero_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = result_q;
  assign rsp_branch = branch_q;
`ifdef ALU_SEQ_DIVZERO_EN
  assign rsp_divzero = divzero_q;
`else
  assign rsp_divzero = 1'b0;
`endif
  assign alu_op = ((state_q == IDLE) || (state_q == DIV)) ? 5'b11111 : op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int unsigned W     = 16;
  localparam logic [4:0]  DIVOP = 5'b00011;
  localparam logic [4:0]  OP_ADD = 5'b00000;
  localparam logic [4:0]  OP_SUB = 5'b00001;
  localparam logic [4:0]  OP_AND = 5'b00010;
  localparam logic [4:0]  OP_XOR = 5'b00100;
  localparam logic [4:0]  OP_BLT = 5'b10100;
  localparam logic [4:0]  OP_BEQ = 5'b10101;
`ifdef ALU_SEQ_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk, rst_n;
  logic         req_valid, req_ready;
  logic [4:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_branch, rsp_divzero;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_branch;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.WIDTH(W), .DIV_OP(DIVOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_divzero(rsp_divzero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_branch(alu_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU behaviour (opcode 11111 and unknown opcodes give zero)
  function automatic logic [W-1:0] alu_res(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic logic alu_br(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_BLT:  return $signed(a) < $signed(b);
      OP_BEQ:  return a == b;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_res(alu_op, alu_a, alu_b);
    alu_branch = alu_br(alu_op, alu_a, alu_b);
  end

  // Reference model of a whole transaction
  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == DIVOP) return (b == 0) ? 16'hFFFF : W'(int'(a) / int'(b));
    return alu_res(op, a, b);
  endfunction

  function automatic logic ref_branch(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (op == DIVOP) ? 1'b0 : alu_br(op, a, b);
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [W-1:0] b);
    if (op != DIVOP) return 1;
    if (DZ_EN && b == 0) return 0;
    return W;
  endfunction

  function automatic logic ref_dz(input logic [4:0] op, input logic [W-1:0] b);
    return DZ_EN && (op == DIVOP) && (b == 0);
  endfunction

  // Present a request for one edge; caller is at posedge+1 with the DUT idle.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid; bounded at 40.
  task automatic wait_rsp(output int lat, output bit saw_ready);
    lat = 0; saw_ready = 1'b0;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_result !== 16'h0) begin errors++; $display("FAIL reset_rsp_result got %0h exp 0", rsp_result); end
    checks++; if ({rsp_branch, rsp_divzero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {rsp_branch, rsp_divzero}); end
    checks++; if (alu_op !== 5'b11111) begin errors++; $display("FAIL reset_alu_op got %b exp 11111", alu_op); end
    checks++; if ({alu_a, alu_b} !== 32'h0) begin errors++; $display("FAIL reset_alu_operands got %0h exp 0", {alu_a, alu_b}); end
  endtask

  task automatic test_add;
    int lat; bit sr;
    issue(OP_ADD, 16'd5, 16'd3);
    wait_rsp(lat, sr);
    checks++; if (lat != 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
    checks++; if (rsp_result !== 16'd8) begin errors++; $display("FAIL add_result got %0d exp 8", rsp_result); end
    checks++; if (rsp_branch !== 1'b0) begin errors++; $display("FAIL add_branch got %0b exp 0", rsp_branch); end
    release_rsp();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL add_return_idle got %b exp 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_divide;
    int lat = 0; bit bad_ready = 0; bit bad_op = 0;
    issue(DIVOP, 16'd100, 16'd7);
    while (!rsp_valid && lat < 40) begin
      if (req_ready) bad_ready = 1'b1;
      if (alu_op !== 5'b11111) bad_op = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 16) begin errors++; $display("FAIL div_latency got %0d exp 16", lat); end
    checks++; if (rsp_result !== 16'd14) begin errors++; $display("FAIL div_result got %0d exp 14", rsp_result); end
    checks++; if (bad_ready) begin errors++; $display("FAIL div_req_ready got 1 exp 0"); end
    checks++; if (bad_op) begin errors++; $display("FAIL div_alu_nop got non-nop exp 11111"); end
    checks++; if ({rsp_branch, rsp_divzero} !== 2'b00) begin errors++; $display("FAIL div_flags got %b exp 00", {rsp_branch, rsp_divzero}); end
    release_rsp();
  endtask

  task automatic test_branch;
    int lat; bit sr;
    issue(OP_BLT, 16'hFFFF, 16'd2);
    wait_rsp(lat, sr);
    checks++; if (rsp_branch !== 1'b1) begin errors++; $display("FAIL blt_taken got %0b exp 1", rsp_branch); end
    checks++; if (rsp_result !== 16'h0) begin errors++; $display("FAIL blt_result got %0h exp 0", rsp_result); end
    release_rsp();
    issue(OP_BLT, 16'd3, 16'd2);
    wait_rsp(lat, sr);
    checks++; if (rsp_branch !== 1'b0) begin errors++; $display("FAIL blt_not_taken got %0b exp 0", rsp_branch); end
    release_rsp();
  endtask

  task automatic test_backpressure;
    int lat; bit sr;
    issue(OP_SUB, 16'd1000, 16'd1);
    wait_rsp(lat, sr);
    // A competing request while busy must be ignored
    req_op = OP_ADD; req_a = 16'd1; req_b = 16'd1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL bp_hold_handshake[%0d] got %b exp 10", i, {rsp_valid, req_ready}); end
      checks++; if (rsp_result !== 16'd999) begin errors++; $display("FAIL bp_hold_result[%0d] got %0d exp 999", i, rsp_result); end
    end
    req_valid = 1'b0;
    release_rsp();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {rsp_valid, req_ready}); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored_req got %0b exp 1", req_ready); end
  endtask

  task automatic test_reset_mid_div;
    int lat; bit sr; bit ghost = 0;
    issue(DIVOP, 16'h1234, 16'd5);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rst_div_state got %b exp 10", {req_ready, rsp_valid}); end
    checks++; if ({alu_op, alu_a, rsp_result} !== {5'b11111, 32'h0}) begin errors++; $display("FAIL rst_div_clear got %0h exp %0h", {alu_op, alu_a, rsp_result}, {5'b11111, 32'h0}); end
    req_op = OP_ADD; req_a = 16'd2; req_b = 16'd2; req_valid = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_first_accept got req_ready %0b exp 0", req_ready); end
    wait_rsp(lat, sr);
    checks++; if (rsp_result !== 16'd4 || lat != 1) begin errors++; $display("FAIL rst_next_op got %0h/%0d exp 4/1", rsp_result, lat); end
    release_rsp();
    repeat (30) begin @(posedge clk); #1; if (rsp_valid) ghost = 1'b1; end
    checks++; if (ghost) begin errors++; $display("FAIL rst_ghost_rsp got 1 exp 0"); end
  endtask

  task automatic test_divzero;
    int lat; bit sr;
    issue(DIVOP, 16'd9, 16'd0);
    wait_rsp(lat, sr);
    checks++; if (lat != (DZ_EN ? 0 : 16)) begin errors++; $display("FAIL dz_latency got %0d exp %0d", lat, DZ_EN ? 0 : 16); end
    checks++; if (rsp_result !== 16'hFFFF) begin errors++; $display("FAIL dz_result got %0h exp ffff", rsp_result); end
    checks++; if (rsp_divzero !== DZ_EN) begin errors++; $display("FAIL dz_flag got %0b exp %0b", rsp_divzero, DZ_EN); end
    release_rsp();
  endtask

  task automatic test_random;
    logic [4:0] ops [8];
    logic [4:0] op; logic [W-1:0] a, b;
    int lat; bit sr; int hold;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_BLT, OP_BEQ, DIVOP, DIVOP};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = a;
        2:       b = W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
      issue(op, a, b);
      wait_rsp(lat, sr);
      checks++; if (lat != ref_lat(op, b) || sr) begin errors++; $display("FAIL rnd_latency[%0d] op %b got %0d exp %0d", n, op, lat, ref_lat(op, b)); end
      checks++; if (rsp_result !== ref_result(op, a, b)) begin errors++; $display("FAIL rnd_result[%0d] op %b a %0h b %0h got %0h exp %0h", n, op, a, b, rsp_result, ref_result(op, a, b)); end
      checks++; if ({rsp_branch, rsp_divzero} !== {ref_branch(op, a, b), ref_dz(op, b)}) begin errors++; $display("FAIL rnd_flags[%0d] got %b exp %b", n, {rsp_branch, rsp_divzero}, {ref_branch(op, a, b), ref_dz(op, b)}); end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== ref_result(op, a, b)) begin errors++; $display("FAIL rnd_hold[%0d] got %0b/%0h exp 1/%0h", n, rsp_valid, rsp_result, ref_result(op, a, b)); end
      end
      release_rsp();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_divide();
    test_branch();
    test_backpressure();
    test_reset_mid_div();
    test_divzero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
